prog_interval_counter: RTL and testbench

Parametrised interval counter/strobe generator for the DTC tester BRAM test path. It counts a run-time programmable number of enabled clock cycles and then emits a one-cycle tick. It supports a one-shot mode (tick once, then raise done) and a periodic mode (tick every period until stopped). It paces BRAM read/write bursts and replaces fixed "count to N" delay counters.

---
 rtl/prog_interval_counter.sv | 106 ++++++++++
 tb/tb_prog_interval_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_interval_counter.sv
// Programmable interval counter / strobe generator.
// Counts enabled cycles up to a latched period, then emits a one-cycle tick.
module prog_interval_counter #(
    parameter int WIDTH          = 8,
    parameter int DEFAULT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;
    logic             tick_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] period_d;
    logic             terminal;

    // A zero period would never reach a terminal count, so it is promoted to 1.
    always_comb begin
        period_d = (period == '0) ? WIDTH'(1) : period;
        terminal = (count_q == period_q - WIDTH'(1));
    end

    // Control FSM with registered outputs; stop > start > terminal > increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= WIDTH'(DEFAULT_PERIOD);
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (start) begin
                state_q  <= RUN;
                period_q <= period_d;
                mode_q   <= mode;
                count_q  <= '0;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (en) begin
                            if (terminal) begin
                                count_q <= '0;
                                tick_q  <= 1'b1;
                                if (!mode_q) begin
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                count_q <= count_q + WIDTH'(1);
                            end
                        end
                    end
                    IDLE: begin
                        count_q <= '0;
                    end
                    DONE: begin
                        count_q <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_prog_interval_counter.sv
// Self-checking bench for prog_interval_counter.
// Directed scenarios followed by random stimulus against an arithmetic model.
module tb_prog_interval_counter;

    localparam int WIDTH = 8;
    localparam int DEFP  = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Model: number of enabled cycles since the last start.
    bit m_active;
    bit m_mode;
    bit m_done;
    bit m_tick;
    int m_p;
    int m_k;

    prog_interval_counter #(
        .WIDTH(WIDTH),
        .DEFAULT_PERIOD(DEFP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .en(en),
        .mode(mode),
        .period(period),
        .count(count),
        .tick(tick),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_cnt;
        exp_cnt = m_active ? (m_k % m_p) : 0;
        chk({tag, ".count"}, int'(count), exp_cnt);
        chk({tag, ".tick"}, int'(tick), int'(m_tick));
        chk({tag, ".busy"}, int'(busy), int'(m_active));
        chk({tag, ".done"}, int'(done), int'(m_done));
    endtask

    task automatic model_reset();
        m_active = 0;
        m_mode   = 0;
        m_done   = 0;
        m_tick   = 0;
        m_p      = DEFP;
        m_k      = 0;
    endtask

    task automatic model_edge(input bit s, input bit sp, input bit e, input bit md, input int p);
        int pw;
        pw = p % (1 << WIDTH);
        m_tick = 0;
        if (sp) begin
            m_active = 0;
            m_done   = 0;
            m_k      = 0;
        end else if (s) begin
            m_active = 1;
            m_done   = 0;
            m_mode   = md;
            m_p      = (pw == 0) ? 1 : pw;
            m_k      = 0;
        end else if (m_active && e) begin
            m_k++;
            if (m_k % m_p == 0) begin
                m_tick = 1;
                if (!m_mode) begin
                    m_active = 0;
                    m_done   = 1;
                    m_k      = 0;
                end
            end
        end
    endtask

    // One clock: drive, edge, update model, check 1 time unit later.
    task automatic cyc(input string tag, input bit s, input bit sp, input bit e,
                       input bit md, input int p);
        start  = s;
        stop   = sp;
        en     = e;
        mode   = md;
        period = WIDTH'(p);
        @(posedge clk);
        model_edge(s, sp, e, md, p);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ticks;
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        period = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 1, 0, 0);

        // Reset asserted mid-run clears outputs without a clock edge.
        cyc("pre_rst", 1, 0, 1, 1, 7);
        cyc("pre_rst", 0, 0, 1, 1, 7);
        cyc("pre_rst", 0, 0, 1, 1, 7);
        async_reset("midrst");
        cyc("post_rst", 0, 0, 1, 0, 0);

        // One-shot, P=5.
        cyc("os5", 1, 0, 1, 0, 5);
        for (int i = 0; i < 5; i++) cyc("os5", 0, 0, 1, 0, 5);
        chk("os5_done", int'(done), 1);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("os5_hold", 0, 0, 1, 0, 5);
            ticks += int'(tick);
        end
        chk("os5_noticks", ticks, 0);

        // Periodic, P=3, then stop.
        cyc("per3", 1, 0, 1, 1, 3);
        for (int i = 0; i < 12; i++) cyc("per3", 0, 0, 1, 1, 3);
        chk("per3_tick12", int'(tick), 1);
        cyc("per3_stop", 0, 1, 1, 1, 3);
        for (int i = 0; i < 3; i++) cyc("per3_idle", 0, 0, 1, 1, 3);

        // en gating: periodic P=4, drop en at count=2 for 3 cycles.
        cyc("gate", 1, 0, 1, 1, 4);
        cyc("gate", 0, 0, 1, 1, 4);
        cyc("gate", 0, 0, 1, 1, 4);
        chk("gate_cnt2", int'(count), 2);
        for (int i = 0; i < 3; i++) cyc("gate_off", 0, 0, 0, 1, 4);
        chk("gate_hold", int'(count), 2);
        cyc("gate", 0, 0, 1, 1, 4);
        cyc("gate", 0, 0, 1, 1, 4);
        chk("gate_tick", int'(tick), 1);

        // Stop coinciding with terminal count.
        cyc("coll", 1, 0, 1, 1, 3);
        cyc("coll", 0, 0, 1, 1, 3);
        cyc("coll", 0, 0, 1, 1, 3);
        cyc("coll_stop", 0, 1, 1, 1, 3);
        chk("coll_notick", int'(tick), 0);

        // Restart at count=2 with a new period.
        cyc("rs", 1, 0, 1, 1, 4);
        cyc("rs", 0, 0, 1, 1, 4);
        cyc("rs", 0, 0, 1, 1, 4);
        cyc("rs_restart", 1, 0, 1, 1, 6);
        for (int i = 0; i < 7; i++) cyc("rs6", 0, 0, 1, 1, 9);

        // period=0 acts as P=1, periodic and one-shot.
        cyc("p0", 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc("p0_per", 0, 0, 1, 1, 0);
        cyc("p0os", 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("p0_os", 0, 0, 1, 0, 0);

        // P=255 periodic: full wrap, then async reset at count=100.
        cyc("p255", 1, 0, 1, 1, 255);
        for (int i = 0; i < 256; i++) cyc("p255", 0, 0, 1, 1, 255);
        chk("p255_cnt1", int'(count), 1);
        cyc("p255b", 1, 0, 1, 1, 255);
        for (int i = 0; i < 100; i++) cyc("p255b", 0, 0, 1, 1, 255);
        chk("p255_cnt100", int'(count), 100);
        async_reset("rst100");
        cyc("post_rst100", 0, 0, 1, 1, 255);

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            bit s, sp, e, md;
            int p;
            s  = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 9) < 8);
            md = 1'($urandom_range(0, 1));
            p  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 7));
            cyc("rand", s, sp, e, md, p);
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
